cpu_run_ctrl: RTL and testbench

Run/halt sequencer for the five-stage pipelined CPU. It releases the pipeline after a start pulse and halts instruction fetch when the ID stage decodes the terminate instruction. After halting it drains the in-flight instructions through EX/MEM/WB, then takes ownership of the MainMemory read port and streams every data word out over a valid/ready interface. It sits beside `CPU`, driving the stage enables and the memory-port select.

---
 rtl/cpu_pkg.sv | 34 +++
 rtl/dump_streamer.sv | 49 ++++
 rtl/cpu_run_ctrl.sv | 132 +++++++++++++
 tb/tb_cpu_run_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: run/halt sequencer state encoding, control bundle and
// the terminate instruction word also decoded by the ID stage.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FLUSH     = 3'd1,
    ST_RUN       = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DUMP_RD   = 3'd4,
    ST_DUMP_WAIT = 3'd5,
    ST_DUMP_OUT  = 3'd6,
    ST_DONE      = 3'd7
  } run_state_t;

  // State-decoded control outputs of the sequencer.
  typedef struct packed {
    logic front_en;
    logic back_en;
    logic pipe_flush;
    logic dump_mem_sel;
    logic running;
    logic done;
  } run_ctl_t;

  localparam int          MEM_WORDS_DEFAULT    = 512;
  localparam int          DRAIN_CYCLES_DEFAULT = 4;
  localparam logic [31:0] TERMINATE_INSTR      = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/dump_streamer.sv
// Memory dump streamer: walks the word index, captures MainMemory read data one
// cycle after the address and holds it under a valid/ready handshake.
module dump_streamer #(
  parameter int MEM_WORDS = 512,
  parameter int AW        = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          cap,
  input  logic          out_phase,
  input  logic [31:0]   rdata,
  input  logic          ready,
  output logic [AW-1:0] addr,
  output logic          valid,
  output logic [31:0]   data,
  output logic [AW-1:0] index,
  output logic          accepted,
  output logic          last_accepted
);

  localparam logic [AW-1:0] LAST = AW'(MEM_WORDS - 1);

  logic [AW-1:0] idx;

  // Ready only matters while the word is offered; the index stops at LAST.
  assign valid         = out_phase;
  assign accepted      = out_phase & ready;
  assign last_accepted = accepted & (idx == LAST);
  assign addr          = idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx   <= '0;
      data  <= '0;
      index <= '0;
    end else begin
      if (clr)
        idx <= '0;
      else if (accepted && !last_accepted)
        idx <= idx + 1'b1;
      if (cap) begin
        data  <= rdata;
        index <= idx;
      end
    end
  end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/halt sequencer beside the five-stage CPU: start, halt on terminate, drain, dump memory.
// Optional macro CPU_RUN_CTRL_CYCLE_COUNT_EN builds the saturating RUN-cycle counter.
module cpu_run_ctrl
  import cpu_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEFAULT,
  parameter int MEM_WORDS    = MEM_WORDS_DEFAULT,
  parameter int AW           = $clog2(MEM_WORDS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          start,
  input  logic          terminate,
  output logic          front_en,
  output logic          back_en,
  output logic          pipe_flush,
  output logic          dump_mem_sel,
  output logic [AW-1:0] dump_addr,
  input  logic [31:0]   dump_rdata,
  output logic          dump_valid,
  input  logic          dump_ready,
  output logic [31:0]   dump_data,
  output logic [AW-1:0] dump_index,
  output logic          running,
  output logic          done,
  output logic [31:0]   cycle_count
);

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  run_state_t    state, state_nxt;
  run_ctl_t      ctl;
  logic [DW-1:0] drain_cnt;
  logic          drain_end;
  logic          dump_accepted, dump_last;

  assign drain_end = (state == ST_DRAIN) && (drain_cnt == '0);

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (start) state_nxt = ST_FLUSH;
      ST_FLUSH:     state_nxt = ST_RUN;
      ST_RUN:       if (terminate) state_nxt = ST_DRAIN;
      ST_DRAIN:     if (drain_end) state_nxt = ST_DUMP_RD;
      ST_DUMP_RD:   state_nxt = ST_DUMP_WAIT;
      ST_DUMP_WAIT: state_nxt = ST_DUMP_OUT;
      ST_DUMP_OUT: begin
        if (dump_last)          state_nxt = ST_DONE;
        else if (dump_accepted) state_nxt = ST_DUMP_RD;
      end
      ST_DONE:      state_nxt = ST_DONE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      ST_FLUSH:     ctl.pipe_flush = 1'b1;
      ST_RUN: begin
        ctl.front_en = 1'b1;
        ctl.back_en  = 1'b1;
        ctl.running  = 1'b1;
      end
      ST_DRAIN:     ctl.back_en = 1'b1;
      ST_DUMP_RD,
      ST_DUMP_WAIT,
      ST_DUMP_OUT:  ctl.dump_mem_sel = 1'b1;
      ST_DONE:      ctl.done = 1'b1;
      default:      ctl = '0;
    endcase
  end

  assign front_en     = ctl.front_en;
  assign back_en      = ctl.back_en;
  assign pipe_flush   = ctl.pipe_flush;
  assign dump_mem_sel = ctl.dump_mem_sel;
  assign running      = ctl.running;
  assign done         = ctl.done;

  // Loaded with DRAIN_CYCLES-1 so DRAIN lasts exactly DRAIN_CYCLES cycles.
  always_ff @(posedge CLK) begin
    if (RESET)
      drain_cnt <= '0;
    else if (state == ST_RUN && terminate)
      drain_cnt <= DRAIN_LOAD;
    else if (state == ST_DRAIN && drain_cnt != '0)
      drain_cnt <= drain_cnt - 1'b1;
  end

`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
  logic [31:0] cyc_q;

  always_ff @(posedge CLK) begin
    if (RESET || state == ST_FLUSH)
      cyc_q <= '0;
    else if (state == ST_RUN)
      cyc_q <= sat_inc32(cyc_q);
  end

  assign cycle_count = cyc_q;
`else
  assign cycle_count = '0;
`endif

  dump_streamer #(
    .MEM_WORDS (MEM_WORDS),
    .AW        (AW)
  ) u_dump (
    .clk           (CLK),
    .rst           (RESET),
    .clr           (drain_end),
    .cap           (state == ST_DUMP_WAIT),
    .out_phase     (state == ST_DUMP_OUT),
    .rdata         (dump_rdata),
    .ready         (dump_ready),
    .addr          (dump_addr),
    .valid         (dump_valid),
    .data          (dump_data),
    .index         (dump_index),
    .accepted      (dump_accepted),
    .last_accepted (dump_last)
  );

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: per-cycle control vector table plus a scoreboard on the dump stream.
module tb_cpu_run_ctrl;

`ifdef CPU_RUN_CTRL_CYCLE_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  localparam int S  = 5;
  localparam int NV = S + 26;

  logic        clk = 1'b0;
  logic        RESET = 1'b1, start = 1'b0, terminate = 1'b0, dump_ready = 1'b0;
  logic        front_en, back_en, pipe_flush, dump_mem_sel, dump_valid, running, done;
  logic [1:0]  dump_addr, dump_index;
  logic [31:0] dump_rdata = '0, dump_data, cycle_count;
  logic [31:0] mem [4];

  cpu_run_ctrl #(.DRAIN_CYCLES(4), .MEM_WORDS(4)) dut (
    .CLK(clk), .RESET(RESET), .start(start), .terminate(terminate),
    .front_en(front_en), .back_en(back_en), .pipe_flush(pipe_flush),
    .dump_mem_sel(dump_mem_sel), .dump_addr(dump_addr), .dump_rdata(dump_rdata),
    .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_data(dump_data),
    .dump_index(dump_index), .running(running), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // One-cycle read latency memory model.
  always @(posedge clk) dump_rdata <= mem[dump_addr];

  typedef struct {
    logic        start;
    logic        term;
    logic [6:0]  o;   // {front,back,flush,running,sel,valid,done}
    logic [31:0] cnt;
  } vec_t;

  typedef struct {
    logic [1:0]  idx;
    logic [31:0] data;
  } exp_t;

  vec_t vt [NV];
  exp_t sb [$];
  int   checks = 0, fails = 0;
  int   cyc = 0, hs_n = 0, last_hs = 0, done_cyc = 0;
  bit   chk_spacing = 1'b0;

  wire [6:0] ctl_bus = {front_en, back_en, pipe_flush, running, dump_mem_sel, dump_valid, done};

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake completes at the next rising edge; compare against the scoreboard.
  always @(negedge clk) begin
    if (!RESET && dump_valid && dump_ready) begin
      if (sb.size() == 0) begin
        chk("hs_unexpected", {dump_index, dump_data}, 34'h3_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("hs_index", dump_index, e.idx);
        chk("hs_data", dump_data, e.data);
      end
      if (chk_spacing && hs_n > 0) chk("hs_spacing", cyc - last_hs, 3);
      hs_n++;
      last_hs = cyc;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    RESET = 1'b1; start = 1'b0; terminate = 1'b0; dump_ready = 1'b0;
    step(); step();
    RESET = 1'b0;
  endtask

  task automatic push_words(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.idx  = 2'(i);
      e.data = 32'hA0 + 32'(i);
      sb.push_back(e);
    end
  endtask

  task automatic run_to_dump();
    int k;
    start = 1'b1; step(); start = 1'b0;
    repeat (3) step();
    terminate = 1'b1; step(); terminate = 1'b0;
    k = 0;
    while (!dump_mem_sel && k < 20) begin step(); k++; end
    chk("dump_entry", dump_mem_sel, 1);
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!done && k < 100) begin step(); k++; end
    chk("done_rise", done, 1);
    done_cyc = cyc;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) mem[i] = 32'hA0 + 32'(i);

    // Control-path vectors: outputs expected after the edge that samples the inputs.
    for (int i = 0; i < NV; i++) begin
      vt[i].start = 1'b0; vt[i].term = 1'b0; vt[i].o = 7'b0; vt[i].cnt = '0;
      if (i == S)
        vt[i].o = 7'b0010000;
      else if (i >= S + 1 && i <= S + 20) begin
        vt[i].o = 7'b1101000; vt[i].cnt = CNT_EN ? 32'(i - S - 1) : 32'd0;
      end else if (i >= S + 21 && i <= S + 24) begin
        vt[i].o = 7'b0100000; vt[i].cnt = CNT_EN ? 32'd20 : 32'd0;
      end else if (i == S + 25) begin
        vt[i].o = 7'b0000100; vt[i].cnt = CNT_EN ? 32'd20 : 32'd0;
      end
    end
    vt[0].term     = 1'b1;   // IDLE ignores terminate
    vt[S].start    = 1'b1;
    vt[S+1].term   = 1'b1;   // FLUSH ignores terminate
    vt[S+2].start  = 1'b1;   // RUN ignores start
    vt[S+21].term  = 1'b1;   // 20th RUN cycle
    vt[S+23].term  = 1'b1;   // DRAIN ignores both
    vt[S+23].start = 1'b1;

    // Reset values, with start asserted alongside RESET.
    RESET = 1'b1; start = 1'b1;
    step(); step();
    chk("reset_ctl", ctl_bus, 7'b0);
    chk("reset_addr_idx", {dump_addr, dump_index}, 4'b0);
    chk("reset_data", dump_data, 0);
    chk("reset_cnt", cycle_count, 0);
    RESET = 1'b0; start = 1'b0;

    for (int i = 0; i < NV; i++) begin
      start = vt[i].start; terminate = vt[i].term;
      step();
      chk($sformatf("vec%0d_ctl", i), ctl_bus, vt[i].o);
      chk($sformatf("vec%0d_cnt", i), cycle_count, vt[i].cnt);
    end
    start = 1'b0; terminate = 1'b0;
    chk("dump_addr0", dump_addr, 0);

    // Full dump with ready held high.
    push_words(4);
    hs_n = 0; chk_spacing = 1'b1; dump_ready = 1'b1;
    wait_done();
    chk("dump_hs_count", hs_n, 4);
    chk("done_after_last", done_cyc, last_hs + 1);
    chk("done_ctl", ctl_bus, 7'b0000001);
    start = 1'b1;
    repeat (3) step();
    start = 1'b0;
    chk("done_ignores_start", ctl_bus, 7'b0000001);

    // Backpressure on word 2.
    do_reset();
    sb.delete(); hs_n = 0; chk_spacing = 1'b0;
    run_to_dump();
    push_words(4);
    dump_ready = 1'b1;
    for (int k = 0; k < 30 && !(dump_valid && dump_index == 2'd2); k++) step();
    chk("stall_reach", {dump_valid, dump_index}, {1'b1, 2'd2});
    dump_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("stall_hold", {dump_valid, dump_index, dump_addr, dump_data}, {1'b1, 2'd2, 2'd2, 32'hA2});
    end
    dump_ready = 1'b1;
    wait_done();
    chk("stall_hs_count", hs_n, 4);

    // RESET while word 1 is offered, then a clean rerun from index 0.
    do_reset();
    sb.delete(); hs_n = 0; chk_spacing = 1'b1;
    run_to_dump();
    push_words(1);
    dump_ready = 1'b1;
    for (int k = 0; k < 30 && !(dump_valid && dump_index == 2'd1); k++) step();
    chk("rst_reach", {dump_valid, dump_index}, {1'b1, 2'd1});
    dump_ready = 1'b0; RESET = 1'b1;
    step();
    RESET = 1'b0;
    chk("rst_mid_ctl", ctl_bus, 7'b0);
    chk("rst_mid_dp", {dump_addr, dump_index, dump_data}, 36'b0);
    chk("rst_mid_cnt", cycle_count, 0);
    chk("rst_sb_empty", sb.size(), 0);
    hs_n = 0;
    run_to_dump();
    push_words(4);
    dump_ready = 1'b1;
    wait_done();
    chk("rerun_hs_count", hs_n, 4);
    chk("rerun_sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
